mux4_rr_arbiter: RTL
====================

# mux4_rr_arbiter

Round-robin arbiter and sequencer for a shared 4-to-1 selector. Up to four requesters compete for one output channel. The block grants one requester at a time and drives the 2-bit select of the downstream 4:1 multiplexer. It also provides a one-hot grant vector and a valid flag so the consumer knows when the mux output is owned.

## Interface
- HOLD_MAX, 8: maximum consecutive cycles one requester may hold the grant while others wait (legal 2..255). Used only when the timeout feature is compiled in.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  4  request lines; bit i high = requester i wants the channel
- gnt  output  4  registered one-hot grant; all-zero when no grant
- sel  output  2  registered mux select = index of current/last grantee
- valid  output  1  high while a grant is active (gnt != 0)

## Operation
- Internal state:
  - FSM: IDLE, GRANT.
  - ptr[1:0]: highest-priority index.
  - cnt[7:0]: hold counter.
- Priority order is ptr, ptr+1, ptr+2, ptr+3, all mod 4. The winner is the first index in that order with req set.
- IDLE, any req set at a clock edge:
  - Go to GRANT.
  - gnt = onehot(winner), sel = winner, valid = 1, cnt = 1.
- IDLE, no req: stay in IDLE. gnt = 0, valid = 0, sel holds its last value.
- GRANT, req[sel] still 1, no timeout: hold gnt/sel. cnt increments and saturates at 255.
- GRANT, req[sel] drops (sampled 0), i.e. release:
  - ptr = sel+1 mod 4.
  - Arbitrate the remaining requests in the same edge using the new ptr.
  - If a winner exists: grant it back-to-back with no bubble, cnt = 1.
  - Otherwise: go to IDLE, gnt = 0, valid = 0.
- On every new grant, ptr is updated to winner+1. The most recent grantee therefore has lowest priority next time.
- gnt is always one-hot or zero. sel always equals the index of the set gnt bit when valid = 1.
- Simultaneous requests: the lowest index at or after ptr wins. No requester is starved when all requesters release within bounded time.
- Requests from non-holders have no effect during GRANT, except through the timeout.
- Reset:
  - gnt = 0, sel = 0, valid = 0, ptr = 0, cnt = 0, state = IDLE.
  - Reset asserted mid-grant drops the grant at that edge; no grant is issued in the same edge.
  - The first arbitration after reset takes place at the first edge with rst = 0.

## Timing
- Request-to-grant latency: 1 cycle. req sampled high at edge N gives gnt/valid visible after edge N.
- Release-to-next-grant latency: 0 bubble cycles. The holder's req low at edge N moves the grant to the next requester after edge N.
- Release-to-idle: valid falls after the edge at which req[sel] is sampled low.
- All outputs are registered; there are no combinational paths from req to outputs.
- The downstream mux sees sel stable for the whole grant. sel changes only at grant edges.

## Configuration
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - At an edge where the FSM is in GRANT, cnt == HOLD_MAX and req[sel] = 1, the grant is forcibly rotated.
  - ptr = sel+1, then arbitrate over req with bit sel masked.
  - If another requester wins: grant it, cnt = 1.
  - If no other requester is pending: the holder keeps the grant and cnt restarts at 1.
  - A holder therefore owns the channel for at most HOLD_MAX consecutive cycles while contended.
  - A preempted requester still asserting req re-enters arbitration normally.
- Undefined:
  - There is no preemption; a holder keeps the grant until it drops req.
  - cnt logic may be removed, and HOLD_MAX is ignored.

## Test plan
- Reset check: drive rst = 1 with req = 4'b1111 for 2 cycles. gnt = 0, sel = 0, valid = 0 throughout. After rst falls, the first grant is gnt = 4'b0001, sel = 0.
- Single request: req = 4'b0100 from idle. One cycle later gnt = 4'b0100, sel = 2, valid = 1. Drop req; valid = 0 after the next edge, and sel stays 2.
- Rotation: hold req = 4'b1111 and have each grantee drop its req for 1 cycle after 3 cycles of ownership. Grant order is 0, 1, 2, 3, 0 with no idle cycles between grants.
- Fairness after wrap: ptr = 3 (last grantee 2), then req = 4'b0101 arrives simultaneously. Grant goes to 0, then to 2 on release.
- Reset mid-grant: assert rst while gnt = 4'b1000. gnt = 0 after that edge. With req = 4'b1000 still high after rst falls, gnt = 4'b1000 one cycle later.
- Timeout (ARB_TIMEOUT_EN, HOLD_MAX = 4): req = 4'b0011 held constant.
  - Requester 0 is granted for exactly 4 cycles, then 1 for 4, then 0.
  - With req = 4'b0001 only, requester 0 keeps the grant indefinitely.
  - Without the macro, requester 0 holds forever under req = 4'b0011.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter
//   Round-robin arbiter and sequencer for a shared 4:1 output channel. Grants
//   one requester at a time, drives the downstream mux select and reports
//   ownership through a one-hot grant vector and a valid flag.
//
// Parameters
//   HOLD_MAX : maximum consecutive grant cycles while contended (2..255).
//              Only affects behaviour when ARB_TIMEOUT_EN is defined.
//
// Ports
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   req   : [3:0] request lines, bit i = requester i wants the channel
//   gnt   : [3:0] registered one-hot grant, zero when nothing is granted
//   sel   : [1:0] registered mux select, index of current/last grantee
//   valid : high while a grant is active
//
// Build option
//   ARB_TIMEOUT_EN : when defined, a holder that has owned the channel for
//                    HOLD_MAX cycles is rotated out if anyone else is waiting.
// -----------------------------------------------------------------------------
module mux4_rr_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       valid
);

`ifdef ARB_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [7:0] cnt;

    // Returns {found, index}: first set bit of r scanning p, p+1, p+2, p+3.
    // Scanning from the lowest priority upward lets the highest priority
    // candidate overwrite the result last.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    logic       holder_req;
    logic       release_evt;
    logic       timeout_evt;
    logic [1:0] arb_ptr;
    logic [3:0] arb_req;
    logic [2:0] pick;
    logic       pick_found;
    logic [1:0] pick_idx;

    always_comb begin
        holder_req  = req[sel];
        release_evt = (state == GRANT) && !holder_req;
        timeout_evt = TIMEOUT_EN && (state == GRANT) && holder_req && (cnt == HOLD_LIM);
        // From IDLE the stored pointer applies; on release or timeout the
        // pointer moves past the current holder before arbitrating.
        arb_ptr     = (state == IDLE) ? ptr : sel + 2'd1;
        // On timeout the holder is masked so anyone else waiting wins.
        arb_req     = timeout_evt ? (req & ~(4'b0001 << sel)) : req;
        pick        = rr_pick(arb_req, arb_ptr);
        pick_found  = pick[2];
        pick_idx    = pick[1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            sel   <= 2'd0;
            valid <= 1'b0;
            ptr   <= 2'd0;
            cnt   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state <= GRANT;
                        gnt   <= 4'b0001 << pick_idx;
                        sel   <= pick_idx;
                        valid <= 1'b1;
                        cnt   <= 8'd1;
                        ptr   <= pick_idx + 2'd1;
                    end else begin
                        gnt   <= 4'b0000;
                        valid <= 1'b0;
                    end
                end
                GRANT: begin
                    if (release_evt || timeout_evt) begin
                        if (pick_found) begin
                            // Back-to-back handover, no idle bubble.
                            gnt   <= 4'b0001 << pick_idx;
                            sel   <= pick_idx;
                            valid <= 1'b1;
                            cnt   <= 8'd1;
                            ptr   <= pick_idx + 2'd1;
                        end else if (timeout_evt) begin
                            // Nobody else waiting: holder keeps the channel.
                            cnt <= 8'd1;
                            ptr <= sel + 2'd1;
                        end else begin
                            state <= IDLE;
                            gnt   <= 4'b0000;
                            valid <= 1'b0;
                            ptr   <= sel + 2'd1;
                        end
                    end else if (cnt != 8'hFF) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
